// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one memory port between the instruction-fetch unit (if_*) and the
// load/store unit (ls_*). Requests are serialised onto a single level-held
// memory request, round-robin on contention. The winner gets a one-cycle done
// pulse with read data. A watchdog aborts a transaction whose acknowledge
// never arrives, and reports the abort through the winner's err flag.
//
// Ports
//   clk_i, rst_ni          clock (rising edge), asynchronous active-low reset
//   if_valid_i, if_addr_i  fetch request (level, held until if_done_o)
//   if_done_o              one-cycle fetch completion pulse
//   if_rdata_o, if_err_o   fetched word / timeout flag, held until next done
//   ls_valid_i, ls_we_i    load/store request (level), 1 = store
//   ls_addr_i, ls_wdata_i  load/store address and store data
//   ls_wstrb_i             store byte enables
//   ls_done_o              one-cycle load/store completion pulse
//   ls_rdata_o, ls_err_o   load data (0 for stores) / timeout flag
//   mem_req_o              memory request, held until ack or abort
//   mem_we_o .. mem_wstrb_o  registered copy of the granted request
//   mem_ack_i, mem_rdata_i one-cycle memory completion with read data
//   busy_o                 high whenever a transaction is in progress

module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    if_valid_i,
  input  logic [ADDR_WIDTH-1:0]   if_addr_i,
  output logic                    if_done_o,
  output logic [DATA_WIDTH-1:0]   if_rdata_o,
  output logic                    if_err_o,
  input  logic                    ls_valid_i,
  input  logic                    ls_we_i,
  input  logic [ADDR_WIDTH-1:0]   ls_addr_i,
  input  logic [DATA_WIDTH-1:0]   ls_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] ls_wstrb_i,
  output logic                    ls_done_o,
  output logic [DATA_WIDTH-1:0]   ls_rdata_o,
  output logic                    ls_err_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb_o,
  input  logic                    mem_ack_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  output logic                    busy_o
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  // Watchdog value seen on the last permitted waiting cycle; the abort fires
  // on that edge so mem_req stays up for exactly TIMEOUT cycles.
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_MEM,
    DONE
  } state_e;

  typedef enum logic {
    GRANT_IF = 1'b0,
    GRANT_LS = 1'b1
  } grant_e;

  state_e              state_q, state_d;
  // Holds the current winner while busy and doubles as last_grant in IDLE.
  grant_e              grant_q, grant_d;
  logic [CNT_W-1:0]    wdog_q, wdog_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [STRB_W-1:0]   mem_wstrb_q, mem_wstrb_d;
  logic                if_done_q, if_done_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic                if_err_q, if_err_d;
  logic                ls_done_q, ls_done_d;
  logic [DATA_WIDTH-1:0] ls_rdata_q, ls_rdata_d;
  logic                ls_err_q, ls_err_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      grant_q     <= GRANT_LS;
      wdog_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      if_done_q   <= 1'b0;
      if_rdata_q  <= '0;
      if_err_q    <= 1'b0;
      ls_done_q   <= 1'b0;
      ls_rdata_q  <= '0;
      ls_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      wdog_q      <= wdog_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      if_done_q   <= if_done_d;
      if_rdata_q  <= if_rdata_d;
      if_err_q    <= if_err_d;
      ls_done_q   <= ls_done_d;
      ls_rdata_q  <= ls_rdata_d;
      ls_err_q    <= ls_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    wdog_d      = wdog_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    if_done_d   = if_done_q;
    if_rdata_d  = if_rdata_q;
    if_err_d    = if_err_q;
    ls_done_d   = ls_done_q;
    ls_rdata_d  = ls_rdata_q;
    ls_err_d    = ls_err_q;

    case (state_q)
      IDLE: begin
        if (if_valid_i || ls_valid_i) begin
          // On a tie the requester that did not win last time goes first.
          if (if_valid_i && ls_valid_i) begin
            grant_d = (grant_q == GRANT_LS) ? GRANT_IF : GRANT_LS;
          end else if (if_valid_i) begin
            grant_d = GRANT_IF;
          end else begin
            grant_d = GRANT_LS;
          end
          if (grant_d == GRANT_IF) begin
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr_i;
            mem_wdata_d = '0;
            mem_wstrb_d = '0;
          end else begin
            mem_we_d    = ls_we_i;
            mem_addr_d  = ls_addr_i;
            mem_wdata_d = ls_wdata_i;
            mem_wstrb_d = ls_wstrb_i;
          end
          mem_req_d = 1'b1;
          wdog_d    = '0;
          state_d   = WAIT_MEM;
        end
      end
      WAIT_MEM: begin
        // A real acknowledge wins over an abort landing on the same edge.
        if (mem_ack_i) begin
          mem_req_d = 1'b0;
          state_d   = DONE;
          if (grant_q == GRANT_IF) begin
            if_rdata_d = mem_rdata_i;
            if_err_d   = 1'b0;
            if_done_d  = 1'b1;
          end else begin
            ls_rdata_d = mem_we_q ? '0 : mem_rdata_i;
            ls_err_d   = 1'b0;
            ls_done_d  = 1'b1;
          end
        end else if (wdog_q == WDOG_LAST) begin
          mem_req_d = 1'b0;
          state_d   = DONE;
          if (grant_q == GRANT_IF) begin
            if_rdata_d = '0;
            if_err_d   = 1'b1;
            if_done_d  = 1'b1;
          end else begin
            ls_rdata_d = '0;
            ls_err_d   = 1'b1;
            ls_done_d  = 1'b1;
          end
        end else begin
          wdog_d = wdog_q + CNT_W'(1);
        end
      end
      DONE: begin
        if_done_d = 1'b0;
        ls_done_d = 1'b0;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign if_done_o   = if_done_q;
  assign if_rdata_o  = if_rdata_q;
  assign if_err_o    = if_err_q;
  assign ls_done_o   = ls_done_q;
  assign ls_rdata_o  = ls_rdata_q;
  assign ls_err_o    = ls_err_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_wstrb_o = mem_wstrb_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Randomised bench for mem_arbiter. Two requester agents issue fetches and
// loads/stores with random gaps; a memory agent answers each request with a
// random latency, sometimes too late so the watchdog fires. A transaction
// level model predicts the round-robin winner, the request fields and the
// completion data/err, and everything is compared through checkOutput.

module tb_mem_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int TO  = 8;
  localparam int BUDGET = 4 * (TO + 4);

  logic          clk = 1'b0;
  logic          rstN;
  logic          ifValid;
  logic [AW-1:0] ifAddr;
  logic          ifDone;
  logic [DW-1:0] ifRdata;
  logic          ifErr;
  logic          lsValid;
  logic          lsWe;
  logic [AW-1:0] lsAddr;
  logic [DW-1:0] lsWdata;
  logic [SW-1:0] lsWstrb;
  logic          lsDone;
  logic [DW-1:0] lsRdata;
  logic          lsErr;
  logic          memReq;
  logic          memWe;
  logic [AW-1:0] memAddr;
  logic [DW-1:0] memWdata;
  logic [SW-1:0] memWstrb;
  logic          memAck;
  logic [DW-1:0] memRdata;
  logic          busy;

  mem_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT   (TO)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rstN),
    .if_valid_i (ifValid),
    .if_addr_i  (ifAddr),
    .if_done_o  (ifDone),
    .if_rdata_o (ifRdata),
    .if_err_o   (ifErr),
    .ls_valid_i (lsValid),
    .ls_we_i    (lsWe),
    .ls_addr_i  (lsAddr),
    .ls_wdata_i (lsWdata),
    .ls_wstrb_i (lsWstrb),
    .ls_done_o  (lsDone),
    .ls_rdata_o (lsRdata),
    .ls_err_o   (lsErr),
    .mem_req_o  (memReq),
    .mem_we_o   (memWe),
    .mem_addr_o (memAddr),
    .mem_wdata_o(memWdata),
    .mem_wstrb_o(memWstrb),
    .mem_ack_i  (memAck),
    .mem_rdata_i(memRdata),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Model state: who won last, and the completion values each requester
  // should currently be holding.
  bit            lastWinLs = 1'b1;
  logic [DW-1:0] expIfRdata = '0;
  logic [DW-1:0] expLsRdata = '0;
  logic          expIfErr = 1'b0;
  logic          expLsErr = 1'b0;
  bit            stopMem = 1'b0;

  // Requester inputs as the arbiter saw them on the most recent rising edge;
  // inputs only change on falling edges, so this is the grant-edge view.
  logic          snapIfValid, snapLsValid, snapLsWe;
  logic [AW-1:0] snapIfAddr, snapLsAddr;
  logic [DW-1:0] snapLsWdata;
  logic [SW-1:0] snapLsWstrb;

  always @(posedge clk) begin
    snapIfValid = ifValid;
    snapIfAddr  = ifAddr;
    snapLsValid = lsValid;
    snapLsWe    = lsWe;
    snapLsAddr  = lsAddr;
    snapLsWdata = lsWdata;
    snapLsWstrb = lsWstrb;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed === expected) passes++;
    else $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  // Serve one memory transaction, starting in the first cycle mem_req is seen.
  task automatic serveOne();
    bit            winLs;
    int            lat, r;
    logic [DW-1:0] data;
    logic          expWe;
    logic [AW-1:0] expAddr;
    logic [DW-1:0] expWdata;
    logic [SW-1:0] expWstrb;
    logic [DW-1:0] expRd;
    logic          expErr;

    if (snapIfValid && snapLsValid) winLs = !lastWinLs;
    else if (snapIfValid) winLs = 1'b0;
    else if (snapLsValid) winLs = 1'b1;
    else begin
      checkOutput("spurious_mem_req", 64'(memReq), 64'(0));
      winLs = 1'b0;
    end
    lastWinLs = winLs;

    if (winLs) begin
      expWe = snapLsWe; expAddr = snapLsAddr;
      expWdata = snapLsWdata; expWstrb = snapLsWstrb;
    end else begin
      expWe = 1'b0; expAddr = snapIfAddr;
      expWdata = '0; expWstrb = '0;
    end
    checkOutput("mem_we", 64'(memWe), 64'(expWe));
    checkOutput("mem_wstrb", 64'(memWstrb), 64'(expWstrb));
    if (winLs) checkOutput("mem_wdata", 64'(memWdata), 64'(expWdata));
    checkOutput("busy_wait", 64'(busy), 64'(1));

    // Latency mix covers the fastest ack, an ack on the last allowed cycle
    // and a timeout followed by an ack arriving during DONE.
    r = $urandom_range(0, 5);
    case (r)
      0: lat = 1;
      1: lat = TO;
      2: lat = TO + 1;
      default: lat = $urandom_range(1, TO + 1);
    endcase
    data = $urandom;

    for (int c = 1; c <= TO; c++) begin
      checkOutput("mem_req_held", 64'(memReq), 64'(1));
      checkOutput("mem_addr_held", 64'(memAddr), 64'(expAddr));
      if (c == lat) begin
        memAck = 1'b1;
        memRdata = data;
        break;
      end
      if (c < TO) @(negedge clk);
    end

    @(negedge clk);
    memAck = 1'b0;
    if (lat > TO) begin
      expRd = '0; expErr = 1'b1;
    end else begin
      expRd = (winLs && expWe) ? '0 : data; expErr = 1'b0;
    end
    if (winLs) begin expLsRdata = expRd; expLsErr = expErr; end
    else begin expIfRdata = expRd; expIfErr = expErr; end

    checkOutput("mem_req_dropped", 64'(memReq), 64'(0));
    checkOutput("if_done", 64'(ifDone), 64'(!winLs));
    checkOutput("ls_done", 64'(lsDone), 64'(winLs));
    checkOutput("if_rdata", 64'(ifRdata), 64'(expIfRdata));
    checkOutput("if_err", 64'(ifErr), 64'(expIfErr));
    checkOutput("ls_rdata", 64'(lsRdata), 64'(expLsRdata));
    checkOutput("ls_err", 64'(lsErr), 64'(expLsErr));
    if (lat == TO + 1) begin
      memAck = 1'b1;
      memRdata = $urandom;
    end

    @(negedge clk);
    memAck = 1'b0;
    checkOutput("if_done_pulse", 64'(ifDone), 64'(0));
    checkOutput("ls_done_pulse", 64'(lsDone), 64'(0));
    checkOutput("busy_idle", 64'(busy), 64'(0));
    checkOutput("if_rdata_held", 64'(ifRdata), 64'(expIfRdata));
    checkOutput("ls_rdata_held", 64'(lsRdata), 64'(expLsRdata));
    checkOutput("ls_err_held", 64'(lsErr), 64'(expLsErr));
  endtask

  task automatic memoryModel();
    while (!stopMem) begin
      @(negedge clk);
      if (memReq === 1'b1) serveOne();
    end
  endtask

  task automatic fetchAgent(input int n);
    int gap, t;
    for (int k = 0; k < n; k++) begin
      gap = (k == 0) ? 0 : $urandom_range(0, 3);
      if (gap > 0) begin
        ifValid = 1'b0;
        repeat (gap) @(negedge clk);
      end
      ifAddr = $urandom;
      ifValid = 1'b1;
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (ifDone !== 1'b1 && t < BUDGET);
      if (ifDone !== 1'b1) checkOutput("if_done_wait", 64'(ifDone), 64'(1));
    end
    ifValid = 1'b0;
  endtask

  task automatic lsuAgent(input int n);
    int gap, t;
    for (int k = 0; k < n; k++) begin
      gap = (k == 0) ? 0 : $urandom_range(0, 3);
      if (gap > 0) begin
        lsValid = 1'b0;
        repeat (gap) @(negedge clk);
      end
      lsWe    = 1'($urandom_range(0, 1));
      lsAddr  = $urandom;
      lsWdata = $urandom;
      lsWstrb = SW'($urandom_range(0, 15));
      lsValid = 1'b1;
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (lsDone !== 1'b1 && t < BUDGET);
      if (lsDone !== 1'b1) checkOutput("ls_done_wait", 64'(lsDone), 64'(1));
    end
    lsValid = 1'b0;
  endtask

  // Reset state, then a reset in the middle of a transaction followed by a
  // fresh fetch that must complete normally.
  task automatic applyStimulus();
    rstN = 1'b0;
    ifValid = 1'b0; ifAddr = '0;
    lsValid = 1'b0; lsWe = 1'b0; lsAddr = '0; lsWdata = '0; lsWstrb = '0;
    memAck = 1'b0; memRdata = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_mem_req", 64'(memReq), 64'(0));
    checkOutput("rst_mem_we", 64'(memWe), 64'(0));
    checkOutput("rst_mem_addr", 64'(memAddr), 64'(0));
    checkOutput("rst_mem_wdata", 64'(memWdata), 64'(0));
    checkOutput("rst_mem_wstrb", 64'(memWstrb), 64'(0));
    checkOutput("rst_if_done", 64'(ifDone), 64'(0));
    checkOutput("rst_ls_done", 64'(lsDone), 64'(0));
    checkOutput("rst_if_rdata", 64'(ifRdata), 64'(0));
    checkOutput("rst_ls_rdata", 64'(lsRdata), 64'(0));
    checkOutput("rst_if_err", 64'(ifErr), 64'(0));
    checkOutput("rst_ls_err", 64'(lsErr), 64'(0));
    checkOutput("rst_busy", 64'(busy), 64'(0));
    rstN = 1'b1;

    // Both agents raise valid together, so the first tie goes to fetch.
    fork
      memoryModel();
      begin
        fork
          fetchAgent(20);
          lsuAgent(20);
        join
        stopMem = 1'b1;
      end
    join

    @(negedge clk);
    ifAddr = 32'h100;
    ifValid = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_req_up", 64'(memReq), 64'(1));
    #2 rstN = 1'b0;
    #1;
    checkOutput("rst_mid_req_async", 64'(memReq), 64'(0));
    checkOutput("rst_mid_busy_async", 64'(busy), 64'(0));
    ifValid = 1'b0;
    memAck = 1'b1;
    memRdata = 32'hBAD0BAD0;
    expIfRdata = '0; expLsRdata = '0; expIfErr = 1'b0; expLsErr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    memAck = 1'b0;
    checkOutput("late_ack_if_done", 64'(ifDone), 64'(0));
    checkOutput("late_ack_ls_done", 64'(lsDone), 64'(0));
    checkOutput("late_ack_busy", 64'(busy), 64'(0));
    checkOutput("late_ack_if_rdata", 64'(ifRdata), 64'(expIfRdata));

    ifAddr = 32'h104;
    ifValid = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_req", 64'(memReq), 64'(1));
    checkOutput("post_rst_addr", 64'(memAddr), 64'(32'h104));
    checkOutput("post_rst_we", 64'(memWe), 64'(0));
    memAck = 1'b1;
    memRdata = 32'h00C0FFEE;
    @(negedge clk);
    memAck = 1'b0;
    ifValid = 1'b0;
    checkOutput("post_rst_if_done", 64'(ifDone), 64'(1));
    checkOutput("post_rst_if_rdata", 64'(ifRdata), 64'(32'h00C0FFEE));
    checkOutput("post_rst_if_err", 64'(ifErr), 64'(0));
    checkOutput("post_rst_req_drop", 64'(memReq), 64'(0));
    @(negedge clk);
    checkOutput("post_rst_done_pulse", 64'(ifDone), 64'(0));
    checkOutput("post_rst_busy", 64'(busy), 64'(0));
  endtask

  initial begin
    applyStimulus();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single memory port between the instruction-fetch unit and the load/store unit. Each requester sees a private valid/done handshake; the arbiter serialises their requests onto one level-held memory request, round-robin on contention, and returns read data and a one-cycle done pulse to the winner. A watchdog aborts memory transactions that never complete, so the core cannot hang on a lost acknowledge.

## Interface
- ADDR_WIDTH, 32, address width of all ports
- DATA_WIDTH, 32, data width of all ports; multiple of 8
- TIMEOUT, 255, cycles to wait for mem_ack before abort; ≥1, counter width $clog2(TIMEOUT+1)
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_valid  in  1  fetch request, level, held until if_done
- if_addr  in  ADDR_WIDTH  fetch address, stable while if_valid
- if_done  out  1  one-cycle completion pulse to fetch
- if_rdata  out  DATA_WIDTH  fetched word, valid with if_done, held until next if_done
- if_err  out  1  timeout flag, valid with if_done
- ls_valid  in  1  load/store request, level, held until ls_done
- ls_we  in  1  1 = store, 0 = load
- ls_addr  in  ADDR_WIDTH  load/store address
- ls_wdata  in  DATA_WIDTH  store data
- ls_wstrb  in  DATA_WIDTH/8  store byte enables
- ls_done  out  1  one-cycle completion pulse to LSU
- ls_rdata  out  DATA_WIDTH  load data, valid with ls_done; 0 for stores
- ls_err  out  1  timeout flag, valid with ls_done
- mem_req  out  1  memory request, level, held until mem_ack or abort
- mem_we, mem_addr, mem_wdata, mem_wstrb  out  1/ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH/8  registered copy of granted request; fetch forces we=0, wstrb=0
- mem_ack  in  1  one-cycle completion from memory; mem_rdata valid same cycle
- mem_rdata  in  DATA_WIDTH  memory read data
- busy  out  1  high in any state except IDLE

## Operation
- States: IDLE, WAIT_MEM, DONE.
- IDLE: sample if_valid/ls_valid. None -> stay. One -> grant it. Both -> grant requester ≠ last_grant. Latch request fields onto mem_* outputs, mem_req<=1, clear watchdog, record grant and last_grant, go WAIT_MEM.
- WAIT_MEM: mem_ack=1 -> mem_req<=0, capture mem_rdata into winner's rdata (ls_rdata<=0 if store), err<=0, winner's done<=1, go DONE. Else watchdog+1; reaching TIMEOUT -> mem_req<=0, rdata<=0, err<=1, done<=1, go DONE.
- DONE: done pulse visible; done<=0, go IDLE. Requester drops valid on the DONE edge, so IDLE never re-grants a finished request.
- mem_ack outside WAIT_MEM ignored (late ack after timeout is discarded).
- Requester fields changed while granted are ignored; mem_* hold the latched copy.
- Loser's request stays pending, no starvation: strict alternation while both valid.
- last_grant resets to LSU, so fetch wins the first tie.

## Timing
- Reset (async, rst_n=0): state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, if_done=0, ls_done=0, if_rdata=0, ls_rdata=0, if_err=0, ls_err=0, busy=0, watchdog=0, last_grant=LSU. Reset mid-transaction drops mem_req immediately; outstanding ack after release is ignored.
- Valid sampled at edge T -> mem_req high from T+1. mem_ack sampled at edge A -> done high in cycle A+1..A+2 (one cycle), IDLE from edge A+2.
- Minimum turnaround: ack in first WAIT_MEM cycle gives done 2 cycles after valid sampled; next grant earliest 3 edges after previous grant.
- Timeout: mem_req stays high for exactly TIMEOUT cycles, then done+err.
- if_done and ls_done never high in the same cycle; at most one mem_req transaction outstanding.

## Test plan
- Single fetch: if_valid, if_addr=0x100, memory acks after 3 cycles with 0x00C0FFEE -> one mem_req with addr 0x100, we=0; if_done one cycle, if_rdata=0x00C0FFEE, if_err=0.
- Store: ls_valid, ls_we=1, addr=0x2000, wdata=0xDEADBEEF, wstrb=0xF, ack after 1 cycle -> mem_we=1, mem_wdata/wstrb match; ls_done pulse, ls_rdata=0.
- Contention: both valid from reset, both held -> order fetch, LSU, fetch, LSU; if_done/ls_done alternate, never overlap.
- Timeout: TIMEOUT=8, no ack -> mem_req high 8 cycles, then ls_done=1 with ls_err=1, ls_rdata=0; ack injected during DONE ignored.
- Back-to-back fetch: ack each first cycle, if_valid re-raised right after done -> grants every 3 cycles, no duplicate transaction.
- Reset mid-WAIT_MEM: rst_n low -> mem_req and busy drop without clock edge; after release, fresh fetch completes normally.
